// File: rtl/sccb_pkg.sv
// rtl/sccb_pkg.sv - shared SCCB types and constants for the OV7670 config path
package sccb_pkg;

   typedef enum logic [1:0] {IDLE, START, BITS, STOP} state_t;

   localparam logic [7:0] OV7670_WR_ADDR = 8'h42;
   localparam logic [7:0] OV7670_RD_ADDR = 8'h43;
   localparam int         SCCB_BYTES     = 3;
   localparam int         BITS_PER_SLOT  = 9;

endpackage

// File: rtl/sccb_quarter_tick.sv
// rtl/sccb_quarter_tick.sv - quarter-SCL-period divider with clear
// Held at zero while cleared; ticks on the last count and advances the quarter index.
module sccb_quarter_tick #(
   parameter int CLK_DIV = 250
) (
   input  logic       i_clk,
   input  logic       i_reset,
   input  logic       i_clear,
   output logic       o_tick,
   output logic [1:0] o_quarter
);

   localparam int               DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DIV_W-1:0] LAST  = DIV_W'(CLK_DIV - 1);

   logic [DIV_W-1:0] r_div;
   logic [1:0]       r_quarter;
   logic             w_tick;

   assign w_tick    = (r_div == LAST);
   assign o_tick    = w_tick;
   assign o_quarter = r_quarter;

   always_ff @(posedge i_clk) begin
      if (i_reset || i_clear) begin
         r_div     <= '0;
         r_quarter <= '0;
      end else if (w_tick) begin
         r_div     <= '0;
         r_quarter <= r_quarter + 2'd1;
      end else begin
         r_div     <= r_div + 1'b1;
      end
   end

endmodule

// File: rtl/sccb_write_ctrl.sv
// rtl/sccb_write_ctrl.sv - SCCB 3-phase write master (START, 3 bytes + ack slots, STOP)
// scl/sdaDrive are registered copies of the decode below, so both lag the FSM by one cycle.
module sccb_write_ctrl
   import sccb_pkg::*;
#(
   parameter int          CLK_DIV     = 250,
   parameter logic [7:0]  DEVICE_ADDR = OV7670_WR_ADDR
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic [7:0] regAddr,
   input  logic [7:0] regData,
   output logic       ready,
   output logic       busy,
   output logic       done,
   output logic       nack,
   output logic       scl,
   output logic       sdaDrive,
   input  logic       sdaIn
);

   state_t     r_state;
   state_t     w_next;
   logic       w_tick;
   logic [1:0] w_quarter;
   logic       w_accept;
   logic       w_slot_end;
   logic       w_last_bit;
   logic       w_last_byte;
   logic       w_scl;
   logic       w_sda;

   logic [1:0] r_byte_idx;
   logic [3:0] r_bit_idx;
   logic [7:0] r_shift;
   logic [7:0] r_addr;
   logic [7:0] r_data;
   logic       r_nack;
   logic       r_done;
   logic       r_scl;
   logic       r_sda_drive;

   sccb_quarter_tick #(.CLK_DIV(CLK_DIV)) u_qtick (
      .i_clk     (clk),
      .i_reset   (reset),
      .i_clear   (r_state == IDLE),
      .o_tick    (w_tick),
      .o_quarter (w_quarter)
   );

   assign w_accept    = start && (r_state == IDLE);
   assign w_slot_end  = w_tick && (w_quarter == 2'd3);
   assign w_last_bit  = (r_bit_idx == 4'(BITS_PER_SLOT - 1));
   assign w_last_byte = (r_byte_idx == 2'(SCCB_BYTES - 1));

   always_ff @(posedge clk) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:  if (start)                                   w_next = START;
         START: if (w_slot_end)                              w_next = BITS;
         BITS:  if (w_slot_end && w_last_bit && w_last_byte) w_next = STOP;
         STOP:  if (w_slot_end)                              w_next = IDLE;
         default:                                            w_next = IDLE;
      endcase
   end

   always_comb begin
      w_scl = 1'b1;
      w_sda = 1'b0;
      case (r_state)
         START: w_sda = w_quarter[1];
         BITS: begin
            w_scl = w_quarter[1];
            w_sda = !w_last_bit && !r_shift[7];
         end
         STOP: begin
            w_scl = (w_quarter != 2'd0);
            w_sda = !w_quarter[1];
         end
         default: ;
      endcase
   end

   // Byte/bit counters and shift register only move at slot boundaries, keeping SDA stable while SCL is high.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_byte_idx <= '0;
         r_bit_idx  <= '0;
         r_shift    <= '0;
         r_addr     <= '0;
         r_data     <= '0;
         r_nack     <= 1'b0;
      end else if (w_accept) begin
         r_addr     <= regAddr;
         r_data     <= regData;
         r_shift    <= DEVICE_ADDR;
         r_byte_idx <= '0;
         r_bit_idx  <= '0;
         r_nack     <= 1'b0;
      end else if (r_state == BITS) begin
         if (w_tick && (w_quarter == 2'd2) && w_last_bit && sdaIn)
            r_nack <= 1'b1;
         if (w_slot_end) begin
            if (w_last_bit) begin
               r_bit_idx  <= '0;
               r_byte_idx <= w_last_byte ? 2'd0 : r_byte_idx + 2'd1;
               r_shift    <= (r_byte_idx == 2'd0) ? r_addr : r_data;
            end else begin
               r_bit_idx  <= r_bit_idx + 4'd1;
               r_shift    <= {r_shift[6:0], 1'b0};
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_scl       <= 1'b1;
         r_sda_drive <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         r_scl       <= w_scl;
         r_sda_drive <= w_sda;
         r_done      <= (r_state == STOP) && w_slot_end;
      end
   end

   assign ready    = (r_state == IDLE);
   assign busy     = (r_state != IDLE);
   assign done     = r_done;
   assign nack     = r_nack;
   assign scl      = r_scl;
   assign sdaDrive = r_sda_drive;

endmodule

// File: tb/tb_sccb_write_ctrl.sv
// tb/tb_sccb_write_ctrl.sv - self-checking bench for sccb_write_ctrl
// Open-drain SDA with an acking slave that decodes bits on SCL rising edges.
module tb_sccb_write_ctrl;

   localparam int CLK_DIV = 4;
   localparam int LAT     = 116 * CLK_DIV;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       start = 1'b0;
   logic [7:0] regAddr = 8'h00;
   logic [7:0] regData = 8'h00;
   logic       ready, busy, done, nack, scl, sdaDrive, sdaIn;
   logic       sda_bus;
   logic       slave_low = 1'b0;
   logic [2:0] nack_mask = 3'b000;

   assign sda_bus = !(sdaDrive || slave_low);
   assign sdaIn   = sda_bus;

   always #5 clk = ~clk;

   sccb_write_ctrl #(.CLK_DIV(CLK_DIV), .DEVICE_ADDR(8'h42)) dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .regAddr  (regAddr),
      .regData  (regData),
      .ready    (ready),
      .busy     (busy),
      .done     (done),
      .nack     (nack),
      .scl      (scl),
      .sdaDrive (sdaDrive),
      .sdaIn    (sdaIn)
   );

   int         total = 0;
   int         bad = 0;
   int         bit_k = 27;
   int         stop_k = 0;
   int         n_start = 0;
   int         n_stop = 0;
   logic [7:0] cur = 8'h00;
   logic [7:0] dec [3];
   logic       p_scl = 1'b1;
   logic       p_sda = 1'b1;

   // Bus monitor / slave: START and STOP are SDA edges with SCL high on two consecutive samples.
   always begin
      logic       s_scl, s_sda;
      logic [7:0] nb;
      @(posedge clk);
      #2;
      s_scl = scl;
      s_sda = sda_bus;
      if (s_scl && p_scl && (s_sda != p_sda)) begin
         if (!s_sda) begin
            n_start++;
            bit_k = 0;
            cur = 8'h00;
            slave_low = 1'b0;
            for (int i = 0; i < 3; i++) dec[i] = 8'h00;
         end else begin
            n_stop++;
            stop_k = bit_k;
         end
      end else if (s_scl && !p_scl) begin
         if (bit_k < 27) begin
            if ((bit_k % 9) < 8) begin
               nb = {cur[6:0], s_sda};
               cur = nb;
               if ((bit_k % 9) == 7) dec[bit_k / 9] = nb;
            end
            bit_k++;
         end
      end else if (!s_scl && p_scl) begin
         slave_low = ((bit_k % 9) == 8) && (bit_k < 27) && !nack_mask[bit_k / 9];
      end
      p_scl = s_scl;
      p_sda = s_sda;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic begin_txn(input logic [7:0] a, input logic [7:0] d, input logic [2:0] m, input bit hold);
      int w = 0;
      nack_mask = m;
      while (!ready && w < 50) begin
         @(negedge clk);
         w++;
      end
      chk("ready_before_start", 32'(ready), 32'd1);
      regAddr = a;
      regData = d;
      start   = 1'b1;
      @(negedge clk);
      if (!hold) start = 1'b0;
      chk("accept_busy", 32'(busy), 32'd1);
      chk("accept_nack_clear", 32'(nack), 32'd0);
   endtask

   task automatic end_txn(input logic [7:0] a, input logic [7:0] d, input logic en, input bit pulse);
      int cnt = 0;
      int s0 = n_start;
      int p0 = n_stop;
      while (!done && cnt < 2000) begin
         @(negedge clk);
         cnt++;
         if (pulse && cnt == 100) begin
            start   = 1'b1;
            regAddr = 8'hEE;
            regData = 8'h11;
         end
         if (pulse && cnt == 101) start = 1'b0;
      end
      chk("latency", 32'(cnt), 32'(LAT));
      chk("done_ready", 32'(ready), 32'd1);
      chk("nack_at_done", 32'(nack), 32'(en));
      chk("byte0_dev", 32'(dec[0]), 32'h42);
      chk("byte1_reg", 32'(dec[1]), 32'(a));
      chk("byte2_data", 32'(dec[2]), 32'(d));
      chk("slots_sent", 32'(bit_k), 32'd27);
      chk("stop_after_last_ack", 32'(stop_k), 32'd27);
      chk("start_cond_count", 32'(n_start - s0), 32'd1);
      chk("stop_cond_count", 32'(n_stop - p0), 32'd1);
      if (pulse) begin
         repeat (20) @(negedge clk);
         chk("no_second_txn", 32'(n_start - s0), 32'd1);
         chk("idle_after_ignored", 32'(ready), 32'd1);
      end
   endtask

   typedef struct {
      logic [7:0] a;
      logic [7:0] d;
      logic [2:0] mask;
      logic       exp_nack;
   } vec_t;

   vec_t vt [5];

   initial begin
      int  w;
      bit  seen_done;
      vt[0] = '{a: 8'h12, d: 8'h80, mask: 3'b000, exp_nack: 1'b0};
      vt[1] = '{a: 8'h12, d: 8'h80, mask: 3'b010, exp_nack: 1'b1};
      vt[2] = '{a: 8'h00, d: 8'hFF, mask: 3'b000, exp_nack: 1'b0};
      vt[3] = '{a: 8'hA5, d: 8'h5A, mask: 3'b100, exp_nack: 1'b1};
      vt[4] = '{a: 8'hFF, d: 8'h00, mask: 3'b001, exp_nack: 1'b1};

      repeat (3) begin
         @(negedge clk);
         chk("reset_idle", 32'({scl, sdaDrive, ready, busy, done, nack}), 32'b101000);
      end
      reset = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 5; i++) begin
         begin_txn(vt[i].a, vt[i].d, vt[i].mask, 1'b0);
         end_txn(vt[i].a, vt[i].d, vt[i].exp_nack, 1'b0);
      end

      begin_txn(8'h3C, 8'hC3, 3'b000, 1'b0);
      end_txn(8'h3C, 8'hC3, 1'b0, 1'b1);

      begin_txn(8'h21, 8'h43, 3'b000, 1'b1);
      end_txn(8'h21, 8'h43, 1'b0, 1'b0);
      regAddr   = 8'h9A;
      regData   = 8'h6B;
      nack_mask = 3'b010;
      @(negedge clk);
      start = 1'b0;
      chk("b2b_busy", 32'(busy), 32'd1);
      chk("b2b_done_single", 32'(done), 32'd0);
      end_txn(8'h9A, 8'h6B, 1'b1, 1'b0);

      begin_txn(8'h33, 8'h0F, 3'b001, 1'b0);
      w = 0;
      while (bit_k != 23 && w < 2000) begin
         @(negedge clk);
         w++;
      end
      chk("reach_byte2_bit4", 32'(bit_k), 32'd23);
      chk("nack_before_reset", 32'(nack), 32'd1);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("reset_mid_idle", 32'({scl, sdaDrive, ready, busy, done, nack}), 32'b101000);
      seen_done = 1'b0;
      repeat (10) begin
         @(negedge clk);
         if (done) seen_done = 1'b1;
      end
      chk("no_done_after_reset", 32'(seen_done), 32'd0);
      begin_txn(8'h55, 8'hAA, 3'b000, 1'b0);
      end_txn(8'h55, 8'hAA, 1'b0, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
